// File: rtl/fifo_sync_nbit.sv
// ============================================================================
// fifo_sync_nbit : single-clock FIFO with registered read port and status flags
// Optional almost_full/almost_empty outputs when FIFO_ALMOST_FLAGS_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_sync_nbit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
`endif
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [AW:0]       w_count_nxt;

  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + c_CNT_ONE;
      2'b01:   w_count_nxt = r_count - c_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is deliberately not reset; writes in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (!reset_p && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_rd_valid <= w_rd_acc;
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == c_DEPTH);
      r_empty    <= (w_count_nxt == '0);
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [AW:0] c_AF_LVL = (AW+1)'(AF_LVL);
  localparam logic [AW:0] c_AE_LVL = (AW+1)'(AE_LVL);

  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_nxt >= c_AF_LVL);
      r_almost_empty <= (w_count_nxt <= c_AE_LVL);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`endif

endmodule

`default_nettype wire
